mul_repadd_unit: RTL and testbench
==================================

Name: mul_repadd_unit

Overview:
Parameterised repeated-addition multiplier that integrates the A/B/P register datapath with its own control FSM. Operands arrive over a single shared input bus on consecutive cycles. The product accumulates as P <= P + A while B decrements to zero. A start/busy/done handshake, an optional smaller-operand swap (fewer iterations), and a full-width 2*WIDTH product are new relative to the earlier fixed 15-bit datapath. Sits between the bus-side sequencer and any consumer of the product.

Parameters:
WIDTH, 15, operand width in bits (A, B, data_in); must be >= 2
SWAP_MIN, 1, 1 = if B > A after load, swap A and B so the loop iterates min(A,B) times; 0 = always iterate B times

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
data_in  input  WIDTH  shared operand bus: A on the start cycle, B on the following cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; product valid on that cycle
product  output  2*WIDTH  P register value
eqz  output  1  combinational (B register == 0)

Behaviour:
- Reset (rst=0, async): state=IDLE; A, B, P = 0. Outputs: busy=0, done=0, product=0, eqz=1. A reset mid-operation aborts immediately with no done pulse.
- IDLE: if start=1 at edge E0, then A <= data_in and next state is LOAD_B. Otherwise hold; P keeps the last product.
- LOAD_B (edge E1): B <= data_in, P <= 0, next state is CHECK. start is ignored.
- CHECK: evaluated in priority order:
  - If SWAP_MIN=1 and B > A (unsigned): A <= B, B <= A, stay in CHECK for one extra cycle. No second swap is possible.
  - Else if B == 0: go to DONE.
  - Else: go to ADD.
- ADD, each cycle:
  - P <= P + zero-extended A, computed at 2*WIDTH bits. Overflow is impossible since the max product is (2^WIDTH-1)^2.
  - B <= B - 1.
  - If B == 1 (last iteration), go to DONE; else stay in ADD.
- DONE: done=1 for exactly one cycle, busy=1, product = final P. Next state is IDLE. start is ignored in DONE.
- Latency: done is visible on the cycle after edge E(2 + n + s).
  - n = iteration count (B after the optional swap).
  - s = 1 if a swap occurred, else 0.
  - Zero operand: done after E2, product 0.
- product is intermediate (not valid) while busy and done=0. It holds the result after DONE until the next LOAD_B clears it.
- start asserted while busy has no effect and is not queued.
- Back-to-back: start may be asserted on the first IDLE cycle after DONE.
- eqz tracks the live B register value, including during load, swap and decrement.
- SWAP_MIN=0: the CHECK swap branch is absent; latency is 2 + B.

Test Plan:
- WIDTH=15, SWAP_MIN=1: start with data_in=7, then data_in=5 -> no swap, 5 ADD cycles, done pulses once, 7 cycles after the start edge, product=35.
- A=3, B=200, SWAP_MIN=1 -> swap occurs, 3 iterations, done 6 cycles after start, product=600. Same operands with SWAP_MIN=0 -> 200 iterations, latency 202, product=600.
- A=1234, B=0 -> done 2 cycles after start, product=0, eqz=1 throughout CHECK/DONE. Repeat with A=0, B=9, SWAP_MIN=1 -> swap, B=0, product=0, latency 3.
- A=B=32767 -> product=1073676289 (bit 29 set, no truncation), done exactly once, busy falls the cycle after done.
- Pulse start with new operands during ADD of an active 7x5 job -> ignored, result still 35. Start on the first IDLE cycle after done with 6x4 -> product=24.
- Drive rst=0 mid-ADD (asynchronously, between edges) -> busy=0, product=0, eqz=1 immediately, no done pulse. After release, a 2x3 job yields product=6.

Source files
------------

// File: rtl/mul_repadd_unit.sv
// Repeated-addition multiplier: loads A then B from one shared bus and accumulates P += A while B counts down.
// done pulses 2+n+s cycles after the start edge (n = iterations, s = 1 if operands were swapped); start is ignored while busy.
module mul_repadd_unit #(
  parameter int WIDTH    = 15,
  parameter int SWAP_MIN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               eqz
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_CHECK  = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               swap_c;

  // A strict B > A test means a swapped pair can never qualify for a second swap.
  assign swap_c = (SWAP_MIN != 0) && (b_q > a_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_CHECK;
      S_CHECK: begin
        if (swap_c)             state_d = S_CHECK;
        else if (b_q == '0)     state_d = S_DONE;
        else                    state_d = S_ADD;
      end
      S_ADD:    if (b_q == WIDTH'(1)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) a_d = data_in;
      end
      S_LOAD_B: begin
        b_d = data_in;
        p_d = '0;
      end
      S_CHECK: begin
        if (swap_c) begin
          a_d = b_q;
          b_d = a_q;
        end
      end
      S_ADD: begin
        p_d = p_q + {{WIDTH{1'b0}}, a_q};
        b_d = b_q - WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign product = p_q;
  assign eqz     = (b_q == '0);

endmodule

// File: tb/tb_mul_repadd_unit.sv
// Bench for mul_repadd_unit: one instance with operand swap enabled, one without, sharing the input bus.
module tb_mul_repadd_unit;
  localparam int W = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   data_in;
  logic           busy1, done1, eqz1;
  logic           busy0, done0, eqz0;
  logic [2*W-1:0] prod1, prod0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_repadd_unit #(.WIDTH(W), .SWAP_MIN(1)) u_dut_swap (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy1), .done(done1), .product(prod1), .eqz(eqz1)
  );

  mul_repadd_unit #(.WIDTH(W), .SWAP_MIN(0)) u_dut_noswap (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy0), .done(done0), .product(prod0), .eqz(eqz0)
  );

  // Called at a negedge with both units idle; returns at a negedge one cycle
  // after the slower unit's done, so a following call starts back-to-back.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject_k, input string name);
    logic [2*W-1:0] exp_p, got1, got0;
    int lat1, lat0, maxlat, seen1, seen0, cnt1, cnt0;
    logic busy_at_done1, busy_at_done0, eqz_at_done1, eqz_at_done0;
    exp_p = (2*W)'(a) * (2*W)'(b);
    lat0  = 2 + int'(b);
    lat1  = (b > a) ? 3 + int'(a) : 2 + int'(b);
    maxlat = (lat1 > lat0) ? lat1 : lat0;
    seen1 = -1; seen0 = -1; cnt1 = 0; cnt0 = 0;
    got1 = '0; got0 = '0;
    busy_at_done1 = 1'b0; busy_at_done0 = 1'b0;
    eqz_at_done1 = 1'b0; eqz_at_done0 = 1'b0;
    start = 1'b1; data_in = a;
    @(negedge clk);
    start = 1'b0; data_in = b;
    for (int k = 1; k <= maxlat + 1; k++) begin
      @(negedge clk);
      if (done1) begin
        cnt1++; seen1 = k; got1 = prod1; busy_at_done1 = busy1; eqz_at_done1 = eqz1;
      end
      if (done0) begin
        cnt0++; seen0 = k; got0 = prod0; busy_at_done0 = busy0; eqz_at_done0 = eqz0;
      end
      if (k == lat1 + 1) begin
        n_checks++;
        if (busy1 !== 1'b0 || prod1 !== exp_p) begin
          n_fail++;
          $display("FAIL %s swap after-done: busy=%0b product=%0d, want busy=0 product=%0d",
                   name, busy1, prod1, exp_p);
        end
      end
      if (k == lat0 + 1) begin
        n_checks++;
        if (busy0 !== 1'b0 || prod0 !== exp_p) begin
          n_fail++;
          $display("FAIL %s noswap after-done: busy=%0b product=%0d, want busy=0 product=%0d",
                   name, busy0, prod0, exp_p);
        end
      end
      if (k == inject_k) begin
        start = 1'b1; data_in = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (seen1 !== lat1 || cnt1 !== 1) begin
      n_fail++;
      $display("FAIL %s swap latency: done at %0d (%0d pulses), want %0d (1 pulse)",
               name, seen1, cnt1, lat1);
    end
    n_checks++;
    if (got1 !== exp_p || busy_at_done1 !== 1'b1 || eqz_at_done1 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s swap result: product=%0d busy=%0b eqz=%0b, want %0d 1 1",
               name, got1, busy_at_done1, eqz_at_done1, exp_p);
    end
    n_checks++;
    if (seen0 !== lat0 || cnt0 !== 1) begin
      n_fail++;
      $display("FAIL %s noswap latency: done at %0d (%0d pulses), want %0d (1 pulse)",
               name, seen0, cnt0, lat0);
    end
    n_checks++;
    if (got0 !== exp_p || busy_at_done0 !== 1'b1 || eqz_at_done0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s noswap result: product=%0d busy=%0b eqz=%0b, want %0d 1 1",
               name, got0, busy_at_done0, eqz_at_done0, exp_p);
    end
  endtask

  task automatic check_idle_reset(input string name);
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || prod1 !== '0 || eqz1 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s swap unit: busy=%0b done=%0b product=%0d eqz=%0b, want 0 0 0 1",
               name, busy1, done1, prod1, eqz1);
    end
    n_checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || prod0 !== '0 || eqz0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s noswap unit: busy=%0b done=%0b product=%0d eqz=%0b, want 0 0 0 1",
               name, busy0, done0, prod0, eqz0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; data_in = '0;
    #22;
    check_idle_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_job(W'(7), W'(5), 4, "7x5 start-during-add");
    run_job(W'(6), W'(4), 0, "6x4 back-to-back");
  endtask

  task automatic test_swap();
    run_job(W'(3), W'(200), 0, "3x200");
  endtask

  task automatic test_zero();
    run_job(W'(1234), W'(0), 0, "1234x0");
    run_job(W'(0), W'(9), 0, "0x9");
  endtask

  task automatic test_max();
    run_job(W'(32767), W'(32767), 0, "max");
  endtask

  task automatic test_reset_mid_add();
    int pulses;
    start = 1'b1; data_in = W'(7);
    @(negedge clk);
    start = 1'b0; data_in = W'(5);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_idle_reset("mid-add reset");
    pulses = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done1 || done0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL aborted job done pulses: %0d, want 0", pulses);
    end
    run_job(W'(2), W'(3), 0, "2x3 after reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 300));
      b = W'($urandom_range(0, 400));
      run_job(a, b, (i % 3 == 0) ? 3 : 0, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_zero();
    test_max();
    test_reset_mid_add();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
